forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl_pkg.sv | 37 +++
 rtl/div_occupancy.sv | 36 +++
 rtl/forward_ctrl.sv | 120 ++++++++++++
 tb/tb_forward_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller and the operand muxes.
package forward_ctrl_pkg;

    // ID-stage operand select codes
    localparam logic [2:0] FWD_NONE   = 3'b000;
    localparam logic [2:0] FWD_ID_ALU = 3'b001;
    // EX-stage select codes
    localparam logic [2:0] FWD_EX_ALU = 3'b010;
    localparam logic [2:0] FWD_MEM_WB = 3'b001;

    localparam int unsigned DIV_CNT_W = 6;

    // Producer record tracked in every stage
    typedef struct packed {
        logic [4:0] dst;
        logic       regwrite;
        logic       memread;
    } slot_t;

    // EX additionally remembers which sources its instruction reads
    typedef struct packed {
        slot_t      base;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
    } ex_slot_t;

    localparam slot_t    SLOT_BUBBLE    = '0;
    localparam ex_slot_t EX_SLOT_BUBBLE = '0;

    // A slot supplies register r only if it writes r; $0 is never forwarded.
    function automatic logic slot_match(slot_t s, logic [4:0] r);
        return s.regwrite && (s.dst == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/div_occupancy.sv
// Divider occupancy counter: loads on launch, counts down to zero.
module div_occupancy
    import forward_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy
);

    logic [DIV_CNT_W-1:0] count_q, count_d;

    // Next count: launch reloads, otherwise saturating decrement
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = DIV_CNT_W'(DIV_CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy = (count_q != '0);

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding select and hazard-stall generation for a 5-stage MIPS-style pipeline.
module forward_ctrl
    import forward_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_branch,
    input  logic [4:0] id_dst,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       id_div_start,
    input  logic       id_use_hilo,
    input  logic       flush,
    output logic [2:0] forwardAin,
    output logic [2:0] forwardBin,
    output logic [2:0] forwardA,
    output logic [2:0] forwardB,
    output logic [2:0] MEMforwardA,
    output logic [2:0] MEMforwardB,
    output logic       stall,
    output logic       div_busy
);

    ex_slot_t ex_q, ex_d;
    slot_t    mem_q, wb_q;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic hz_load_use, hz_branch, hz_div;
    logic stall_raw, div_load;

    div_occupancy #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_occupancy (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (div_load),
        .busy  (div_busy)
    );

    // Hazard terms from tracking state against the current ID instruction
    always_comb begin
        ex_hit_rs   = id_use_rs && slot_match(ex_q.base, id_rs);
        ex_hit_rt   = id_use_rt && slot_match(ex_q.base, id_rt);
        mem_hit_rs  = id_use_rs && slot_match(mem_q, id_rs);
        mem_hit_rt  = id_use_rt && slot_match(mem_q, id_rt);
        hz_load_use = ex_q.base.memread && (ex_hit_rs || ex_hit_rt);
        hz_branch   = id_branch && (ex_hit_rs || ex_hit_rt ||
                                    (mem_q.memread && (mem_hit_rs || mem_hit_rt)));
        hz_div      = div_busy && (id_div_start || id_use_hilo);
        stall_raw   = hz_load_use || hz_branch || hz_div;
        div_load    = id_div_start && !stall_raw && !flush;
    end

    // Select codes; everything is forced to zero while reset is held
    always_comb begin
        forwardA    = FWD_NONE;
        forwardB    = FWD_NONE;
        MEMforwardA = FWD_NONE;
        MEMforwardB = FWD_NONE;
        forwardAin  = FWD_NONE;
        forwardBin  = FWD_NONE;
        stall       = 1'b0;
        if (rst_n) begin
            stall = stall_raw;
            if (ex_q.use_rs && slot_match(mem_q, ex_q.rs) && !mem_q.memread) begin
                forwardA = FWD_EX_ALU;
            end
            if (ex_q.use_rt && slot_match(mem_q, ex_q.rt) && !mem_q.memread) begin
                forwardB = FWD_EX_ALU;
            end
            // The mux lets the MEM code override, so suppress it when EX/MEM is newer
            if (ex_q.use_rs && slot_match(wb_q, ex_q.rs) && (forwardA != FWD_EX_ALU)) begin
                MEMforwardA = FWD_MEM_WB;
            end
            if (ex_q.use_rt && slot_match(wb_q, ex_q.rt) && (forwardB != FWD_EX_ALU)) begin
                MEMforwardB = FWD_MEM_WB;
            end
            if (id_branch && mem_hit_rs && !mem_q.memread) begin
                forwardAin = FWD_ID_ALU;
            end
            if (id_branch && mem_hit_rt && !mem_q.memread) begin
                forwardBin = FWD_ID_ALU;
            end
        end
    end

    // Next EX slot: bubble on stall or flush, otherwise capture the ID instruction
    always_comb begin
        ex_d = EX_SLOT_BUBBLE;
        if (!stall_raw && !flush) begin
            ex_d.base.dst      = id_dst;
            ex_d.base.regwrite = id_regwrite;
            ex_d.base.memread  = id_memread;
            ex_d.rs            = id_rs;
            ex_d.rt            = id_rt;
            ex_d.use_rs        = id_use_rs;
            ex_d.use_rt        = id_use_rt;
        end
    end

    // Tracking slots advance every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= EX_SLOT_BUBBLE;
            mem_q <= SLOT_BUBBLE;
            wb_q  <= SLOT_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q.base;
            wb_q  <= mem_q;
        end
    end

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench: directed pipeline scenarios plus randomized traffic vs a reference model.
module tb_forward_ctrl;

    localparam int unsigned DIVC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_use_rs, id_use_rt, id_branch, id_regwrite, id_memread;
    logic       id_div_start, id_use_hilo, flush;
    logic [2:0] forwardAin, forwardBin, forwardA, forwardB, MEMforwardA, MEMforwardB;
    logic       stall, div_busy;

    int total = 0;
    int bad   = 0;

    forward_ctrl #(
        .DIV_CYCLES (DIVC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_branch    (id_branch),
        .id_dst       (id_dst),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .id_div_start (id_div_start),
        .id_use_hilo  (id_use_hilo),
        .flush        (flush),
        .forwardAin   (forwardAin),
        .forwardBin   (forwardBin),
        .forwardA     (forwardA),
        .forwardB     (forwardB),
        .MEMforwardA  (MEMforwardA),
        .MEMforwardB  (MEMforwardB),
        .stall        (stall),
        .div_busy     (div_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
        logic       ds;
        logic       hl;
    } instr_t;

    function automatic instr_t mk(logic [4:0] dst, logic wr, logic ld, logic [4:0] rs, logic urs,
                                  logic [4:0] rt, logic urt, logic br, logic ds, logic hl);
        instr_t i;
        i.dst = dst; i.wr = wr; i.ld = ld; i.rs = rs; i.urs = urs;
        i.rt = rt; i.urt = urt; i.br = br; i.ds = ds; i.hl = hl;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    endfunction
    function automatic instr_t alu(logic [4:0] d, logic [4:0] s, logic [4:0] t);
        return mk(d, 1, 0, s, 1, t, 1, 0, 0, 0);
    endfunction
    function automatic instr_t lw(logic [4:0] d, logic [4:0] s);
        return mk(d, 1, 1, s, 1, 5'd0, 0, 0, 0, 0);
    endfunction
    function automatic instr_t beq(logic [4:0] s, logic [4:0] t);
        return mk(5'd0, 0, 0, s, 1, t, 1, 1, 0, 0);
    endfunction
    function automatic instr_t divi(logic [4:0] s, logic [4:0] t);
        return mk(5'd0, 0, 0, s, 1, t, 1, 0, 1, 0);
    endfunction
    function automatic instr_t mfhi(logic [4:0] d);
        return mk(d, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
    endfunction

    task automatic drive(input instr_t i);
        id_rs = i.rs; id_rt = i.rt; id_use_rs = i.urs; id_use_rt = i.urt;
        id_branch = i.br; id_dst = i.dst; id_regwrite = i.wr; id_memread = i.ld;
        id_div_start = i.ds; id_use_hilo = i.hl;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_fA"}, 8'(forwardA), 8'd0);
        check_eq({pfx, "_fB"}, 8'(forwardB), 8'd0);
        check_eq({pfx, "_mA"}, 8'(MEMforwardA), 8'd0);
        check_eq({pfx, "_mB"}, 8'(MEMforwardB), 8'd0);
        check_eq({pfx, "_fAin"}, 8'(forwardAin), 8'd0);
        check_eq({pfx, "_fBin"}, 8'(forwardBin), 8'd0);
        check_eq({pfx, "_stall"}, 8'(stall), 8'd0);
        check_eq({pfx, "_busy"}, 8'(div_busy), 8'd0);
    endtask

    // Leaves the bench just after a negedge with reset released
    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        drive(nop());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // In-flight instructions, youngest first: ex, mem, wb; divider as cycles remaining.
    instr_t m_ex, m_mem, m_wb;
    int     m_div;

    function automatic bit produces(instr_t s, logic [4:0] r);
        return s.wr && (s.dst == r) && (r != 5'd0);
    endfunction

    function automatic bit model_stall(instr_t cur);
        instr_t     older [2];
        logic [4:0] src   [2];
        bit         used  [2];
        bit         hz = 0;
        older[0] = m_ex;  older[1] = m_mem;
        src[0]   = cur.rs; src[1]  = cur.rt;
        used[0]  = cur.urs; used[1] = cur.urt;
        for (int s = 0; s < 2; s++) begin
            for (int d = 0; d < 2; d++) begin
                if (used[s] && produces(older[d], src[s])) begin
                    // distance 1 = EX, distance 2 = MEM
                    if (d == 0 && older[d].ld) hz = 1;
                    if (cur.br && (d == 0 || older[d].ld)) hz = 1;
                end
            end
        end
        if (m_div > 0 && (cur.ds || cur.hl)) hz = 1;
        return hz;
    endfunction

    function automatic logic [2:0] ex_code(logic use_src, logic [4:0] src);
        return (use_src && produces(m_mem, src) && !m_mem.ld) ? 3'b010 : 3'b000;
    endfunction

    function automatic logic [2:0] wb_code(logic use_src, logic [4:0] src);
        return (use_src && produces(m_wb, src) && ex_code(use_src, src) != 3'b010) ? 3'b001
                                                                                 : 3'b000;
    endfunction

    function automatic logic [2:0] id_code(instr_t cur, logic use_src, logic [4:0] src);
        return (cur.br && use_src && produces(m_mem, src) && !m_mem.ld) ? 3'b001 : 3'b000;
    endfunction

    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        int     n, nb;
        instr_t cur;
        bit     est, fl;

        // ---- reset holds every output at zero whatever ID presents ----
        rst_n = 1'b0;
        flush = 1'b0;
        drive(mk(5'd3, 1, 1, 5'd3, 1, 5'd3, 1, 1, 1, 1));
        #2;
        check_all_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ---- ALU -> ALU, EX/MEM forward ----
        do_reset();
        drive(alu(5'd3, 5'd1, 5'd2));
        @(negedge clk);
        drive(alu(5'd4, 5'd3, 5'd5));
        #1 check_eq("alu_dep_id_stall", 8'(stall), 8'd0);
        @(negedge clk);
        drive(nop());
        #1;
        check_eq("exmem_fA", 8'(forwardA), 8'd2);
        check_eq("exmem_mA", 8'(MEMforwardA), 8'd0);
        check_eq("exmem_stall", 8'(stall), 8'd0);

        // ---- distance 2 forward from MEM/WB on both operands ----
        do_reset();
        drive(alu(5'd3, 5'd1, 5'd2));
        @(negedge clk);
        drive(nop());
        @(negedge clk);
        drive(alu(5'd6, 5'd3, 5'd3));
        @(negedge clk);
        drive(nop());
        #1;
        check_eq("memwb_fA", 8'(forwardA), 8'd0);
        check_eq("memwb_mA", 8'(MEMforwardA), 8'd1);
        check_eq("memwb_mB", 8'(MEMforwardB), 8'd1);

        // ---- two producers: newer wins; $0 never forwarded ----
        do_reset();
        drive(alu(5'd3, 5'd1, 5'd2));
        @(negedge clk);
        drive(alu(5'd3, 5'd1, 5'd2));
        @(negedge clk);
        drive(alu(5'd4, 5'd3, 5'd0));
        @(negedge clk);
        drive(nop());
        #1;
        check_eq("newer_fA", 8'(forwardA), 8'd2);
        check_eq("newer_mA", 8'(MEMforwardA), 8'd0);
        check_eq("r0_fB", 8'(forwardB), 8'd0);
        check_eq("r0_mB", 8'(MEMforwardB), 8'd0);

        // ---- load then dependent branch: two stall cycles ----
        do_reset();
        drive(lw(5'd2, 5'd1));
        @(negedge clk);
        drive(beq(5'd2, 5'd7));
        n = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (!stall) break;
            n++;
            @(negedge clk);
        end
        check_eq("ld_br_stall_cycles", 8'(n), 8'd2);
        check_eq("ld_br_fAin", 8'(forwardAin), 8'd0);

        // ---- ALU then dependent branch: one stall, then ID forward ----
        do_reset();
        drive(alu(5'd2, 5'd1, 5'd1));
        @(negedge clk);
        drive(beq(5'd7, 5'd2));
        n = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (!stall) break;
            n++;
            @(negedge clk);
        end
        check_eq("alu_br_stall_cycles", 8'(n), 8'd1);
        check_eq("alu_br_fBin", 8'(forwardBin), 8'd1);
        check_eq("alu_br_fAin", 8'(forwardAin), 8'd0);

        // ---- load-use: one stall, then MEM/WB forward ----
        do_reset();
        drive(lw(5'd2, 5'd1));
        @(negedge clk);
        drive(alu(5'd4, 5'd2, 5'd1));
        n = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (!stall) break;
            n++;
            @(negedge clk);
        end
        check_eq("ld_use_stall_cycles", 8'(n), 8'd1);
        @(negedge clk);
        drive(nop());
        #1;
        check_eq("ld_use_mA", 8'(MEMforwardA), 8'd1);
        check_eq("ld_use_fA", 8'(forwardA), 8'd0);

        // ---- divide then mfhi ----
        do_reset();
        drive(divi(5'd1, 5'd2));
        #1 check_eq("div_launch_stall", 8'(stall), 8'd0);
        @(negedge clk);
        drive(mfhi(5'd5));
        n = 0;
        nb = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (div_busy) nb++;
            if (stall) n++;
            if (!stall && !div_busy) break;
            @(negedge clk);
        end
        check_eq("div_busy_cycles", 8'(nb), 8'(DIVC));
        check_eq("div_stall_cycles", 8'(n), 8'(DIVC));
        check_eq("div_done_busy", 8'(div_busy), 8'd0);

        // ---- reset mid-divide with a load in EX ----
        do_reset();
        drive(divi(5'd1, 5'd2));
        @(negedge clk);
        drive(lw(5'd2, 5'd1));
        #1 check_eq("div_lw_stall", 8'(stall), 8'd0);
        @(negedge clk);
        drive(alu(5'd4, 5'd2, 5'd1));
        #1;
        check_eq("pre_rst_stall", 8'(stall), 8'd1);
        check_eq("pre_rst_busy", 8'(div_busy), 8'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_stall", 8'(stall), 8'd0);
        check_eq("post_rst_busy", 8'(div_busy), 8'd0);

        // ---- randomized traffic against the model ----
        do_reset();
        m_ex = nop(); m_mem = nop(); m_wb = nop(); m_div = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                drive(mk(rreg(), 1, 1, rreg(), 1, rreg(), 1, 1, 1, 1));
                #1;
                check_all_zero("rnd_rst");
                m_ex = nop(); m_mem = nop(); m_wb = nop(); m_div = 0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cur.rs  = rreg();
            cur.rt  = rreg();
            cur.urs = 1'($urandom_range(0, 3) != 0);
            cur.urt = 1'($urandom_range(0, 1));
            cur.br  = 1'($urandom_range(0, 3) == 0);
            cur.dst = rreg();
            cur.wr  = 1'($urandom_range(0, 3) != 0);
            cur.ld  = cur.wr && ($urandom_range(0, 2) == 0);
            cur.ds  = 1'($urandom_range(0, 9) == 0);
            cur.hl  = 1'($urandom_range(0, 7) == 0);
            fl      = ($urandom_range(0, 7) == 0);
            drive(cur);
            flush = fl;
            #1;
            est = model_stall(cur);
            check_eq("rnd_fA", 8'(forwardA), 8'(ex_code(m_ex.urs, m_ex.rs)));
            check_eq("rnd_fB", 8'(forwardB), 8'(ex_code(m_ex.urt, m_ex.rt)));
            check_eq("rnd_mA", 8'(MEMforwardA), 8'(wb_code(m_ex.urs, m_ex.rs)));
            check_eq("rnd_mB", 8'(MEMforwardB), 8'(wb_code(m_ex.urt, m_ex.rt)));
            check_eq("rnd_fAin", 8'(forwardAin), 8'(id_code(cur, cur.urs, cur.rs)));
            check_eq("rnd_fBin", 8'(forwardBin), 8'(id_code(cur, cur.urt, cur.rt)));
            check_eq("rnd_stall", 8'(stall), 8'(est));
            check_eq("rnd_busy", 8'(div_busy), 8'(m_div > 0));
            // advance the model to the next cycle
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (est || fl) ? nop() : cur;
            if (cur.ds && !est && !fl) m_div = DIVC;
            else if (m_div > 0) m_div--;
            @(negedge clk);
        end
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
